// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared constants and helpers for the multi-channel pushbutton debouncer.
//   DEBOUNCE_CYCLES_DEFAULT : default stability window in clk cycles
//   REPEAT_DELAY_DEFAULT    : default hold time before the first auto-repeat
//   REPEAT_PERIOD_DEFAULT   : default spacing of later auto-repeat pulses
//   min_cnt_width()         : smallest counter width w with 2**w >= cycles
// -----------------------------------------------------------------------------
package debounce_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 65535;
  localparam int unsigned REPEAT_DELAY_DEFAULT    = 12000000;
  localparam int unsigned REPEAT_PERIOD_DEFAULT   = 3000000;

  // The stability counter only ever reaches cycles-1, so 2**w >= cycles is enough.
  function automatic int unsigned min_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((64'd1 << w) < 64'(cycles))) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounced input: two-flop synchroniser with polarity fold-in, stability
// counter, debounced level, registered press/release pulses and an optional
// typematic auto-repeat pulse (compiled in when DEBOUNCE_REPEAT_EN is defined).
// Ports:
//   clk      : clock, all logic on posedge
//   rst_n    : asynchronous active-low reset
//   button_i : raw asynchronous input, asserted level set by ACTIVE_LOW
//   state_o  : debounced level, 1 = pressed
//   down_o   : one-cycle pulse in the first cycle state_o reads 1
//   up_o     : one-cycle pulse in the first cycle state_o reads 0
//   repeat_o : one-cycle auto-repeat pulse while held (0 without the macro)
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned REP_W           = 24,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_i,
  output logic state_o,
  output logic down_o,
  output logic up_o,
  output logic repeat_o
);

  localparam logic             INV      = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0_q, sync1_q;
  logic             state_q, state_d;
  logic             down_q, up_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle, toggle;

  always_comb begin
    idle    = (sync1_q == state_q);
    toggle  = !idle && (cnt_q == CNT_LAST);
    state_d = state_q ^ toggle;
    // Any cycle agreeing with the current level restarts the window, and an
    // accepted toggle clears it, so the counter can never wrap.
    if (idle || toggle) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      sync0_q <= button_i ^ INV;
      sync1_q <= sync0_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      // Pulses are registered alongside the level so they line up with it.
      down_q  <= toggle && !state_q;
      up_q    <= toggle && state_q;
    end
  end

  assign state_o = state_q;
  assign down_o  = down_q;
  assign up_o    = up_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_hit, repeat_q;

  // Counter sits at 0 while released, so it reads 0 in the down-pulse cycle
  // and the first hit lands REPEAT_DELAY cycles after button_down. Reloading
  // to DELAY-PERIOD makes later hits PERIOD apart.
  always_comb begin
    rep_hit = state_q && (rep_q == REP_LAST);
    if (!state_q) begin
      rep_d = '0;
    end else if (rep_hit) begin
      rep_d = REP_RELOAD;
    end else begin
      rep_d = rep_q + REP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q    <= '0;
      repeat_q <= 1'b0;
    end else begin
      rep_q    <= rep_d;
      // Gating with the next level suppresses a pulse in the button_up cycle.
      repeat_q <= rep_hit && state_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  logic unused_rep;
  assign unused_rep = ^{REP_W, REPEAT_DELAY, REPEAT_PERIOD};
  assign repeat_o   = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
// N-channel pushbutton debouncer. Each channel is an independent
// debounce_channel; the top only replicates them and ORs the levels.
// Optional auto-repeat is enabled by defining DEBOUNCE_REPEAT_EN.
// Ports:
//   clk           : clock, all logic on posedge
//   rst_n         : asynchronous active-low reset
//   button        : raw asynchronous inputs (NUM_CH), polarity per ACTIVE_LOW
//   button_state  : debounced levels, 1 = pressed
//   button_down   : one-cycle press pulses
//   button_up     : one-cycle release pulses
//   button_repeat : one-cycle auto-repeat pulses (0 without the macro)
//   any_pressed   : OR of button_state
// -----------------------------------------------------------------------------
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = min_cnt_width(DEBOUNCE_CYCLES),
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned REP_W           = 24,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] button,
  output logic [NUM_CH-1:0] button_state,
  output logic [NUM_CH-1:0] button_down,
  output logic [NUM_CH-1:0] button_up,
  output logic [NUM_CH-1:0] button_repeat,
  output logic              any_pressed
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .CNT_W           (CNT_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .REP_W           (REP_W),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .button_i (button[g]),
      .state_o  (button_state[g]),
      .down_o   (button_down[g]),
      .up_o     (button_up[g]),
      .repeat_o (button_repeat[g])
    );
  end

  assign any_pressed = |button_state;

endmodule

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
// Directed bench for debounce_multi with NUM_CH=4, DEBOUNCE_CYCLES=4,
// ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_PERIOD=3. Repeat expectations follow
// DEBOUNCE_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] button;
  logic [3:0] button_state, button_down, button_up, button_repeat;
  logic       any_pressed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .NUM_CH          (4),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1),
    .REP_W           (24),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .button        (button),
    .button_state  (button_state),
    .button_down   (button_down),
    .button_up     (button_up),
    .button_repeat (button_repeat),
    .any_pressed   (any_pressed)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] st, input logic [3:0] dn,
                         input logic [3:0] up, input logic any);
    chk({tag, ".state"}, 32'(button_state), 32'(st));
    chk({tag, ".down"},  32'(button_down),  32'(dn));
    chk({tag, ".up"},    32'(button_up),    32'(up));
    chk({tag, ".any"},   32'(any_pressed),  32'(any));
  endtask

  logic [3:0] exp_rep;

  initial begin
    // Reset with every button released (active-low: all ones).
    rst_n  = 1'b0;
    button = 4'b1111;
    #2;
    chk_out("rst_async", 4'h0, 4'h0, 4'h0, 1'b0);
    chk("rst_async.rep", 32'(button_repeat), 32'h0);
    repeat (3) tick();
    chk_out("rst_hold", 4'h0, 4'h0, 4'h0, 1'b0);
    chk("rst_hold.rep", 32'(button_repeat), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk($sformatf("idle%0d", i),
          32'({button_state, button_down, button_up, button_repeat, any_pressed}), 32'h0);
    end

    // Clean press on ch0: level and down pulse after edge 6.
    button = 4'b1110;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk_out($sformatf("press0_e%0d", e), (e >= 6) ? 4'b0001 : 4'b0000,
              (e == 6) ? 4'b0001 : 4'b0000, 4'b0000, (e >= 6));
    end

    // Glitch on ch1: low 3, high 1, then low for good. Final low starts being
    // sampled at edge 5, so the press lands on edge 10.
    button = 4'b1100;
    for (int e = 1; e <= 11; e++) begin
      tick();
      chk_out($sformatf("glitch1_e%0d", e), (e >= 10) ? 4'b0011 : 4'b0001,
              (e == 10) ? 4'b0010 : 4'b0000, 4'b0000, 1'b1);
      if (e == 3) button = 4'b1110;
      if (e == 4) button = 4'b1100;
    end

    // Release ch0 and press ch2 together.
    button = 4'b1001;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk_out($sformatf("simul_e%0d", e), (e >= 6) ? 4'b0110 : 4'b0011,
              (e == 6) ? 4'b0100 : 4'b0000, (e == 6) ? 4'b0001 : 4'b0000, 1'b1);
    end

    // Press ch3, then a half-cycle reset two edges in.
    button = 4'b0001;
    tick();
    tick();
    chk_out("pre_rst", 4'b0110, 4'b0000, 4'b0000, 1'b1);
    rst_n = 1'b0;
    #3;
    chk_out("mid_rst", 4'h0, 4'h0, 4'h0, 1'b0);
    chk("mid_rst.rep", 32'(button_repeat), 32'h0);
    #2;
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk_out($sformatf("redetect_e%0d", e), (e >= 6) ? 4'b1110 : 4'b0000,
              (e == 6) ? 4'b1110 : 4'b0000, 4'b0000, (e >= 6));
    end

    // Release everything.
    button = 4'b1111;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk_out($sformatf("relall_e%0d", e), (e >= 6) ? 4'b0000 : 4'b1110,
              4'b0000, (e == 6) ? 4'b1110 : 4'b0000, (e < 6));
    end

    // Hold ch0 for auto-repeat: down at edge 6, repeats at 16,19,...
    // Release after edge 28, so up lands on edge 34 where a repeat would
    // otherwise have fallen.
    button = 4'b1110;
    for (int e = 1; e <= 44; e++) begin
      tick();
      exp_rep = 4'b0000;
`ifdef DEBOUNCE_REPEAT_EN
      if (e >= 16 && e <= 33 && ((e - 16) % 3 == 0)) exp_rep = 4'b0001;
`endif
      chk($sformatf("rep_e%0d", e), 32'(button_repeat), 32'(exp_rep));
      chk_out($sformatf("hold0_e%0d", e), (e >= 6 && e < 34) ? 4'b0001 : 4'b0000,
              (e == 6) ? 4'b0001 : 4'b0000, (e == 34) ? 4'b0001 : 4'b0000,
              (e >= 6 && e < 34));
      if (e == 28) button = 4'b1111;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parameterised N-channel push-button debouncer: the next generation of the single-channel debouncer.
Each channel synchronises a glitchy asynchronous input into clk, filters it with a programmable-length stability counter, and produces a level plus one-cycle press/release pulses.
Adds configurable polarity, depth and channel count, an any-activity summary, and an optional auto-repeat (typematic) pulse.
Sits between board pushbuttons/switches and user logic (counters, menu FSMs).

Parameters:
NUM_CH, 4, number of independent input channels
CNT_W, 16, stability counter width; requires DEBOUNCE_CYCLES <= 2**CNT_W
DEBOUNCE_CYCLES, 65535, consecutive stable synchronised cycles needed to accept a new level (>= 1)
ACTIVE_LOW, 1, 1 = raw input asserted when 0 (inverted at sync stage); 0 = asserted when 1
REP_W, 24, auto-repeat counter width
REPEAT_DELAY, 12000000, cycles held before the first repeat pulse (>= 1, < 2**REP_W)
REPEAT_PERIOD, 3000000, cycles between subsequent repeat pulses (>= 1, < 2**REP_W)

Ports:
clk  input  1  single clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
button  input  NUM_CH  raw asynchronous inputs, polarity per ACTIVE_LOW
button_state  output  NUM_CH  debounced level, 1 = pressed
button_down  output  NUM_CH  1-cycle pulse when a channel becomes pressed
button_up  output  NUM_CH  1-cycle pulse when a channel becomes released
button_repeat  output  NUM_CH  1-cycle auto-repeat pulse (0 when the feature is compiled out)
any_pressed  output  1  OR of button_state

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. While rst_n=0, sync flops = released level (0 after polarity), counters = 0, and all outputs = 0 (button_state, down, up, repeat, any_pressed). Reset mid-debounce discards progress. Releasing reset while a button is held yields a normal press detection, not an immediate state.
- Per channel, fully independent:
  - sync0 <= raw XOR ACTIVE_LOW; sync1 <= sync0.
  - idle = (sync1 == button_state).
  - If idle: cnt <= 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1: button_state <= ~button_state and cnt <= 0; otherwise cnt <= cnt+1.
- Latency: with the raw input stable after the change, button_state toggles at edge DEBOUNCE_CYCLES+2, counting the first edge that samples the new raw level as edge 1.
- Glitch rejection: any single cycle with sync1 == state restarts the count from 0.
- Pulses: button_down/button_up are registered. Each is high exactly in the first cycle button_state shows its new value: down on 0->1, up on 1->0. They are never both high on one channel. Simultaneous events on different channels each pulse in the same cycle.
- Counter never wraps: it clears on toggle or on idle, so CNT_W only bounds DEBOUNCE_CYCLES.
- any_pressed is combinational from the button_state register outputs.

Optional Feature:
DEBOUNCE_REPEAT_EN
- Defined:
  - Each channel has a REP_W repeat counter, cleared whenever button_state=0 and in the down-pulse cycle.
  - While held, the counter increments. When it reaches REPEAT_DELAY-1, button_repeat pulses for one cycle, and the counter reloads to REPEAT_DELAY-REPEAT_PERIOD. Net effect: the first repeat comes REPEAT_DELAY cycles after button_down, then one every REPEAT_PERIOD cycles.
  - Release stops repeats immediately. No repeat pulse occurs in the button_up cycle.
  - The repeat counter is reset by rst_n.
- Undefined: no repeat counters are synthesised; button_repeat is tied to 0.

Decomposition:
- Package debounce_pkg holds:
  - default constants DEBOUNCE_CYCLES_DEFAULT, REPEAT_DELAY_DEFAULT, REPEAT_PERIOD_DEFAULT
  - a function computing the minimum counter width from a cycle count (clog2-style)
- Sub-module debounce_channel contains one channel (sync, counter, state, pulses, optional repeat). The top instantiates it NUM_CH times in a generate loop and ORs the states.

Test Plan:
- Bench parameters for all scenarios: NUM_CH=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset and idle: hold rst_n=0 with button=4'b1111, then release -> all outputs 0 and remain 0 for 50 cycles.
- Clean press: drive button[0] 1->0 and hold -> button_state[0] rises at edge 6 after the change; button_down[0] high for exactly that one cycle; any_pressed=1; other channels unaffected.
- Glitch rejection: button[1] low for 3 cycles, high 1 cycle, low 3 cycles -> no state change and no pulse. Then hold low -> press detected 6 edges after the final low begins.
- Release plus simultaneity: release ch0 and press ch2 in the same cycle -> button_up[0] and button_down[2] pulse in the same cycle; any_pressed stays 1.
- Async reset mid-count: assert rst_n for half a cycle 2 edges into a press on ch3 -> outputs clear immediately. The held button is re-detected 6 edges after reset release.
- Auto-repeat (with DEBOUNCE_REPEAT_EN): hold ch0 -> button_repeat[0] pulses 10 cycles after button_down[0], then every 3 cycles. Release -> no further repeat pulses. Without the macro, button_repeat stays 0.
